serial_addsub_n: RTL and testbench

- Parametrised, handshaked successor to the team's 4-bit serial bit adder.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell.
- Adds a start/busy/done handshake, an add/subtract mode, a signed-overflow flag and asynchronous reset.
- Sits between the MicroBlaze custom-logic register interface and the operand/result registers; trades throughput for minimal area.

---
 rtl/serial_arith_pkg.sv | 26 ++
 rtl/serial_addsub_n_if.sv | 30 +++
 rtl/serial_fa_cell.sv | 20 ++
 rtl/serial_addsub_n.sv | 128 ++++++++++++
 tb/tb_serial_addsub_n.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial add/subtract datapath:
// FSM state encoding, default operand width and a portable clog2.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 for tools that lack $clog2 in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_addsub_n_if.sv
// Register-side handshake bundle for serial_addsub_n.
// The master drives the request and operands; the slave returns status and result.
interface serial_addsub_n_if
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, sub, x, y, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, sub, x, y, ci,
        output busy, done, s, co, ovf
    );

endinterface

// File: rtl/serial_fa_cell.sv
// Single 1-bit full adder used as the only arithmetic element of the serial datapath.
// Carry and sum nets are kept through synthesis so they stay probeable in hardware.
module serial_fa_cell (
    input  logic ci,
    input  logic a,
    input  logic b,
    output logic co,
    output logic s
);

    (* keep = "true" *) logic w_sum;
    (* keep = "true" *) logic w_carry;

    assign w_sum   = a ^ b ^ ci;
    assign w_carry = (a & b) | (ci & (a ^ b));

    assign s  = w_sum;
    assign co = w_carry;

endmodule

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor with start/busy/done handshake.
// One full-adder cell processes one bit per clock, LSB first; the result,
// carry-out and signed overflow are published on the final bit and held.
module serial_addsub_n
    import serial_arith_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_addsub_n_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_xr;
    logic [WIDTH-1:0] r_yr;
    // Only the upper WIDTH-1 result bits need storing; the last sum bit
    // comes straight from the adder when the result is published.
    logic [WIDTH-2:0] r_sr;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;

    logic             w_ready;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_busy;
    logic             w_done;

    serial_fa_cell u_fa (
        .ci (r_c),
        .a  (r_xr[0]),
        .b  (r_yr[0]),
        .co (w_carry),
        .s  (w_sum)
    );

    assign w_ready   = (r_state == IDLE) || (r_state == DONE);
    assign w_accept  = w_ready && bus.start;
    assign w_run     = (r_state == RUN);
    assign w_last    = w_run && (r_cnt == LAST_BIT);
    assign w_sr_next = {w_sum, r_sr};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: DONE accepts a new start just like IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = bus.start ? RUN : IDLE;
            RUN:     w_next_state = w_last ? DONE : RUN;
            DONE:    w_next_state = bus.start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            RUN:     w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, per-bit shift/add, and result publication on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xr  <= '0;
            r_yr  <= '0;
            r_sr  <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_s   <= '0;
            r_co  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                // Subtract is x + ~y + ~ci, i.e. x - y - ci.
                r_xr  <= bus.x;
                r_yr  <= bus.sub ? ~bus.y : bus.y;
                r_c   <= bus.sub ^ bus.ci;
                r_cnt <= '0;
            end else if (w_run) begin
                r_xr  <= r_xr >> 1;
                r_yr  <= r_yr >> 1;
                r_sr  <= w_sr_next[WIDTH-1:1];
                r_c   <= w_carry;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Carry into the MSB is r_c on the last bit, so overflow is
            // taken from it directly instead of from a separate c_msb flop.
            if (w_last) begin
                r_s   <= w_sr_next;
                r_co  <= w_carry;
                r_ovf <= r_c ^ w_carry;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.s    = r_s;
    assign bus.co   = r_co;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Self-checking bench for serial_addsub_n at WIDTH = 8, 2, 16 and 33,
// compared against an arithmetic reference model.
module tb_serial_addsub_n;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] last_es;

    always #5 clk = ~clk;

    serial_addsub_n_if #(.WIDTH(8))  if8  ();
    serial_addsub_n_if #(.WIDTH(2))  if2  ();
    serial_addsub_n_if #(.WIDTH(16)) if16 ();
    serial_addsub_n_if #(.WIDTH(33)) if33 ();

    serial_addsub_n #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_addsub_n #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
    serial_addsub_n #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    serial_addsub_n #(.WIDTH(33)) u_dut33 (.clk(clk), .rst_n(rst_n), .bus(if33));

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input int w, input logic sb, input logic [63:0] xa,
                                  input logic [63:0] ya, input logic c,
                                  output logic [63:0] es, output logic eco, output logic eovf);
        logic [63:0] mask;
        logic [63:0] full;
        longint sx, sy, t, hi, lo;
        mask = (64'd1 << w) - 64'd1;
        sx = xa[w-1] ? longint'(xa) - (longint'(1) << w) : longint'(xa);
        sy = ya[w-1] ? longint'(ya) - (longint'(1) << w) : longint'(ya);
        if (!sb) begin
            full = xa + ya + 64'(c);
            eco  = full[w];
            t    = sx + sy + longint'(c);
        end else begin
            full = xa - ya - 64'(c);
            eco  = (xa >= ya + 64'(c));
            t    = sx - sy - longint'(c);
        end
        es   = full & mask;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        eovf = (t > hi) || (t < lo);
    endfunction

    task automatic drive(input int w, input logic st, input logic sb, input logic [63:0] xa,
                         input logic [63:0] ya, input logic c);
        case (w)
            2:  begin if2.start  = st; if2.sub  = sb; if2.x  = xa[1:0];  if2.y  = ya[1:0];  if2.ci  = c; end
            8:  begin if8.start  = st; if8.sub  = sb; if8.x  = xa[7:0];  if8.y  = ya[7:0];  if8.ci  = c; end
            16: begin if16.start = st; if16.sub = sb; if16.x = xa[15:0]; if16.y = ya[15:0]; if16.ci = c; end
            default: begin if33.start = st; if33.sub = sb; if33.x = xa[32:0]; if33.y = ya[32:0]; if33.ci = c; end
        endcase
    endtask

    task automatic observe(input int w, output logic b, output logic d, output logic [63:0] sv,
                           output logic c, output logic o);
        case (w)
            2:  begin b = if2.busy;  d = if2.done;  sv = 64'(if2.s);  c = if2.co;  o = if2.ovf;  end
            8:  begin b = if8.busy;  d = if8.done;  sv = 64'(if8.s);  c = if8.co;  o = if8.ovf;  end
            16: begin b = if16.busy; d = if16.done; sv = 64'(if16.s); c = if16.co; o = if16.ovf; end
            default: begin b = if33.busy; d = if33.done; sv = 64'(if33.s); c = if33.co; o = if33.ovf; end
        endcase
    endtask

    // One operation; with hold=0 start drops and operands are scrambled after capture.
    task automatic run_op(input int w, input logic sb, input logic [63:0] xa, input logic [63:0] ya,
                          input logic c, input bit hold, input string tag);
        logic [63:0] es, so;
        logic eco, eovf, b, d, co_o, ov_o;
        int cycles, busy_n;
        bit seen;
        cycles = 0;
        busy_n = 0;
        seen   = 0;
        model(w, sb, xa, ya, c, es, eco, eovf);
        last_es = es;
        drive(w, 1'b1, sb, xa, ya, c);
        while (!seen && cycles < w + 4) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!hold) drive(w, 1'b0, ~sb, {$urandom, $urandom}, {$urandom, $urandom}, ~c);
            observe(w, b, d, so, co_o, ov_o);
            if (b === 1'b1) busy_n++;
            if (d === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen || cycles != w + 1) begin
            n_fail++;
            $display("FAIL %s w=%0d latency: got %0d cycles (seen=%0d), expected %0d", tag, w, cycles, seen, w + 1);
        end
        n_tests++;
        if (busy_n != w) begin
            n_fail++;
            $display("FAIL %s w=%0d busy_cycles: got %0d, expected %0d", tag, w, busy_n, w);
        end
        n_tests++;
        if (so !== es) begin
            n_fail++;
            $display("FAIL %s w=%0d s: got %h, expected %h (x=%h y=%h sub=%0d ci=%0d)", tag, w, so, es, xa, ya, sb, c);
        end
        n_tests++;
        if (co_o !== eco) begin
            n_fail++;
            $display("FAIL %s w=%0d co: got %b, expected %b (x=%h y=%h sub=%0d ci=%0d)", tag, w, co_o, eco, xa, ya, sb, c);
        end
        n_tests++;
        if (ov_o !== eovf) begin
            n_fail++;
            $display("FAIL %s w=%0d ovf: got %b, expected %b (x=%h y=%h sub=%0d ci=%0d)", tag, w, ov_o, eovf, xa, ya, sb, c);
        end
    endtask

    task automatic test_reset();
        int ws[4] = '{8, 2, 16, 33};
        logic b, d, co_o, ov_o;
        logic [63:0] so;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) drive(ws[k], 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            observe(ws[k], b, d, so, co_o, ov_o);
            n_tests++;
            if ({b, d, co_o, ov_o} !== 4'b0000 || so !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_state w=%0d: got busy=%b done=%b s=%h co=%b ovf=%b, expected all 0",
                         ws[k], b, d, so, co_o, ov_o);
            end
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        run_op(8, 1'b0, 64'h3C, 64'h0F, 1'b0, 0, "add_basic");
        run_op(8, 1'b0, 64'h7F, 64'h01, 1'b0, 0, "add_ovf");
        run_op(8, 1'b0, 64'hFF, 64'h01, 1'b1, 0, "add_carry");
    endtask

    task automatic test_sub();
        run_op(8, 1'b1, 64'h05, 64'h07, 1'b0, 0, "sub_borrow");
        run_op(8, 1'b1, 64'h80, 64'h01, 1'b0, 0, "sub_ovf");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_op(8, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 255)),
                   64'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1, "back_to_back");
        drive(8, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_midrun();
        logic b, d, co_o, ov_o;
        logic [63:0] so;
        int cycles;
        bit seen;
        cycles = 0;
        seen   = 0;
        drive(8, 1'b1, 1'b0, 64'h12, 64'h34, 1'b0);
        while (!seen && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 2 || cycles == 3) drive(8, 1'b1, 1'b1, 64'hFF, 64'hF0, 1'b1);
            else drive(8, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
            observe(8, b, d, so, co_o, ov_o);
            if (d === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen || cycles != 9 || so !== 64'h46 || co_o !== 1'b0 || ov_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_midrun: got cycles=%0d s=%h co=%b ovf=%b, expected cycles=9 s=46 co=0 ovf=0",
                     cycles, so, co_o, ov_o);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            observe(8, b, d, so, co_o, ov_o);
            n_tests++;
            if (so !== 64'h46 || d !== 1'b0 || b !== 1'b0) begin
                n_fail++;
                $display("FAIL s_hold idle%0d: got s=%h done=%b busy=%b, expected s=46 done=0 busy=0", i, so, d, b);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic b, d, co_o, ov_o;
        logic [63:0] so;
        int pulses;
        drive(8, 1'b1, 1'b0, 64'hAA, 64'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            drive(8, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        observe(8, b, d, so, co_o, ov_o);
        n_tests++;
        if ({b, d, co_o, ov_o} !== 4'b0000 || so !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_midop: got busy=%b done=%b s=%h co=%b ovf=%b, expected all 0",
                     b, d, so, co_o, ov_o);
        end
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            observe(8, b, d, so, co_o, ov_o);
            if (d !== 1'b0 || b !== 1'b0) pulses++;
        end
        #2 rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            observe(8, b, d, so, co_o, ov_o);
            if (d !== 1'b0 || b !== 1'b0) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_abort: got %0d cycles with busy/done after abort, expected 0", pulses);
        end
        run_op(8, 1'b0, 64'hAA, 64'h55, 1'b0, 0, "reset_fresh");
    endtask

    task automatic test_width_sweep();
        int ws[3] = '{2, 16, 33};
        logic [63:0] mask;
        for (int k = 0; k < 3; k++) begin
            mask = (64'd1 << ws[k]) - 64'd1;
            for (int i = 0; i < 1000; i++)
                run_op(ws[k], 1'($urandom_range(0, 1)), {$urandom, $urandom} & mask,
                       {$urandom, $urandom} & mask, 1'($urandom_range(0, 1)), 0, "sweep");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_ignore_midrun();
        test_reset_midop();
        test_width_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
